// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
//
// Watches a multiplexed 7-segment display bus and rebuilds the 4-digit
// hexadecimal value that is being shown on it. Each {AN,Cathodes} sample
// has to stay unchanged for STABLE_CYCLES clocks before it is accepted as a
// digit. One digit is accepted per dwell. When all four digit slots have
// been filled, the complete frame is published on value/dp.
//
// Ports
//   sysclk     in   1  clock, rising-edge
//   BTNU       in   1  synchronous active-high reset
//   AN         in   4  anode enables, active-low, AN[0] = digit 0
//   Cathodes   in   8  segments active-low, [6:0] = gfedcba, [7] = dp
//   value      out 16  last complete frame, digit 3 in [15:12]
//   dp         out  4  decimal points of last complete frame, active-high
//   valid      out  1  one-cycle pulse when value/dp update
//   digit_stb  out  1  one-cycle pulse per accepted legal digit
//   seg_err    out  1  one-cycle pulse per accepted illegal segment pattern
// ---------------------------------------------------------------------------
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        sysclk,
  input  logic        BTNU,
  input  logic [3:0]  AN,
  input  logic [7:0]  Cathodes,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic        valid,
  output logic        digit_stb,
  output logic        seg_err
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  typedef enum logic {WAIT, HELD} state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic [11:0]      r_prevSample;
  logic             r_prevValid;
  logic [7:0]       r_count;
  logic [3:0][3:0]  r_slots;
  logic [3:0]       r_slotDp;
  logic [3:0]       r_seen;
  logic [15:0]      r_value;
  logic [3:0]       r_dp;
  logic             r_valid;
  logic             r_digitStb;
  logic             r_segErr;

  logic [11:0]      w_sample;
  logic             w_changed;
  logic [7:0]       w_nextCount;
  logic             w_candidate;
  logic [1:0]       w_slotIdx;
  logic [3:0]       w_slotMask;
  logic [6:0]       w_segs;
  logic             w_legal;
  logic [3:0]       w_nibble;
  logic             w_capture;
  logic [3:0][3:0]  w_newSlots;
  logic [3:0]       w_newSlotDp;
  logic [3:0]       w_newSeen;

  assign w_sample = {AN, Cathodes};

  // The first edge after reset has no previous sample to compare with.
  // Treating it as a change makes a sample that was already on the bus
  // start counting from 1.
  assign w_changed = !r_prevValid || (w_sample != r_prevSample);

  // Stability counter: restart at 1 on a change, then count up and
  // saturate at STABLE_CYCLES.
  always_comb begin
    w_nextCount = r_count;
    if (w_changed) begin
      w_nextCount = 8'd1;
    end else if (r_count < STABLE) begin
      w_nextCount = r_count + 8'd1;
    end
  end

  // Only a sample with exactly one anode driven low selects a digit slot.
  always_comb begin
    w_candidate = 1'b1;
    w_slotIdx   = 2'd0;
    w_slotMask  = 4'b0000;
    unique case (AN)
      4'b1110: begin w_slotIdx = 2'd0; w_slotMask = 4'b0001; end
      4'b1101: begin w_slotIdx = 2'd1; w_slotMask = 4'b0010; end
      4'b1011: begin w_slotIdx = 2'd2; w_slotMask = 4'b0100; end
      4'b0111: begin w_slotIdx = 2'd3; w_slotMask = 4'b1000; end
      default: w_candidate = 1'b0;
    endcase
  end

  // Convert the active-low bus to active-high gfedcba and look up the hex
  // digit. Any other pattern, including blank, is illegal.
  assign w_segs = ~Cathodes[6:0];

  always_comb begin
    w_legal  = 1'b1;
    w_nibble = 4'h0;
    case (w_segs)
      7'h3F: w_nibble = 4'h0;
      7'h06: w_nibble = 4'h1;
      7'h5B: w_nibble = 4'h2;
      7'h4F: w_nibble = 4'h3;
      7'h66: w_nibble = 4'h4;
      7'h6D: w_nibble = 4'h5;
      7'h7D: w_nibble = 4'h6;
      7'h07: w_nibble = 4'h7;
      7'h7F: w_nibble = 4'h8;
      7'h6F: w_nibble = 4'h9;
      7'h77: w_nibble = 4'hA;
      7'h7C: w_nibble = 4'hB;
      7'h39: w_nibble = 4'hC;
      7'h5E: w_nibble = 4'hD;
      7'h79: w_nibble = 4'hE;
      7'h71: w_nibble = 4'hF;
      default: w_legal = 1'b0;
    endcase
  end

  // A change of sample always leaves HELD. The capture test therefore
  // treats "changed" the same as being in WAIT. This is what lets
  // STABLE_CYCLES=1 capture on the very edge where a new sample appears.
  assign w_capture = ((r_state == WAIT) || w_changed) &&
                     (w_nextCount == STABLE) && w_candidate;

  // Next-state logic: enter HELD on a capture, fall back to WAIT on any
  // change, otherwise stay.
  always_comb begin
    w_nextState = r_state;
    if (w_capture) begin
      w_nextState = HELD;
    end else if (w_changed) begin
      w_nextState = WAIT;
    end
  end

  // State register.
  always_ff @(posedge sysclk) begin
    if (BTNU) begin
      r_state <= WAIT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Slot contents as they would look after writing the current digit.
  // The frame output loads from these when this digit completes the frame.
  always_comb begin
    w_newSlots             = r_slots;
    w_newSlots[w_slotIdx]  = w_nibble;
    w_newSlotDp            = r_slotDp;
    w_newSlotDp[w_slotIdx] = ~Cathodes[7];
    w_newSeen              = r_seen | w_slotMask;
  end

  // Datapath: sample history, counter, slots and the registered outputs.
  // Pulses default low every cycle. Reset overrides any capture.
  always_ff @(posedge sysclk) begin
    if (BTNU) begin
      r_prevSample <= '0;
      r_prevValid  <= 1'b0;
      r_count      <= '0;
      r_slots      <= '0;
      r_slotDp     <= '0;
      r_seen       <= '0;
      r_value      <= '0;
      r_dp         <= '0;
      r_valid      <= 1'b0;
      r_digitStb   <= 1'b0;
      r_segErr     <= 1'b0;
    end else begin
      r_prevSample <= w_sample;
      r_prevValid  <= 1'b1;
      r_count      <= w_nextCount;
      r_valid      <= 1'b0;
      r_digitStb   <= 1'b0;
      r_segErr     <= 1'b0;
      if (w_capture) begin
        if (w_legal) begin
          r_slots    <= w_newSlots;
          r_slotDp   <= w_newSlotDp;
          r_digitStb <= 1'b1;
          if (w_newSeen == 4'b1111) begin
            r_value <= w_newSlots;
            r_dp    <= w_newSlotDp;
            r_valid <= 1'b1;
            r_seen  <= 4'b0000;
          end else begin
            r_seen  <= w_newSeen;
          end
        end else begin
          r_segErr <= 1'b1;
          r_seen   <= r_seen & ~w_slotMask;
        end
      end
    end
  end

  assign value     = r_value;
  assign dp        = r_dp;
  assign valid     = r_valid;
  assign digit_stb = r_digitStb;
  assign seg_err   = r_segErr;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_decoder
//
// Directed bench for seg7_scan_decoder. A table of dwells drives the
// default STABLE_CYCLES=4 instance. Each row gives one {AN,Cathodes}
// value, how long it is held, and the pulse counts and frame expected
// afterwards. Hand-written sequences then cover:
//   - reset part-way through a frame, and the capture latency after reset
//   - a second instance built with STABLE_CYCLES=1
// ---------------------------------------------------------------------------
module tb_seg7_scan_decoder;

  logic        sysclk;
  logic        BTNU;
  logic [3:0]  AN;
  logic [7:0]  Cathodes;

  logic [15:0] value;
  logic [3:0]  dp;
  logic        valid;
  logic        digit_stb;
  logic        seg_err;

  logic [15:0] value1;
  logic [3:0]  dp1;
  logic        valid1;
  logic        digitStb1;
  logic        segErr1;

  int checkCount = 0;
  int failCount  = 0;

  typedef struct {
    logic [3:0]  an;
    logic [7:0]  cath;
    int          cycles;
    int          expStb;
    int          expErr;
    int          expValid;
    logic [15:0] expValue;
    logic [3:0]  expDp;
  } vec_t;

  vec_t vecs[22];

  seg7_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .sysclk(sysclk), .BTNU(BTNU), .AN(AN), .Cathodes(Cathodes),
    .value(value), .dp(dp), .valid(valid),
    .digit_stb(digit_stb), .seg_err(seg_err)
  );

  seg7_scan_decoder #(.STABLE_CYCLES(1)) dut1 (
    .sysclk(sysclk), .BTNU(BTNU), .AN(AN), .Cathodes(Cathodes),
    .value(value1), .dp(dp1), .valid(valid1),
    .digit_stb(digitStb1), .seg_err(segErr1)
  );

  // 10 ns clock.
  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  // Safety net in case the run never reaches its summary line.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against its expected value, and keep score.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Hold one {AN,Cathodes} value for a number of cycles. Outputs are sampled
  // 1 ns after each rising edge, and the pulses of the default instance are
  // counted.
  task automatic applyStimulus(input logic [3:0] an, input logic [7:0] cath,
                               input int cycles, output int nStb,
                               output int nErr, output int nValid);
    AN       = an;
    Cathodes = cath;
    nStb     = 0;
    nErr     = 0;
    nValid   = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge sysclk);
      #1;
      if (digit_stb) nStb++;
      if (seg_err)   nErr++;
      if (valid)     nValid++;
    end
  endtask

  // Main test sequence.
  initial begin
    int nStb, nErr, nValid, lat;
    logic [3:0] s1An[4];
    logic [7:0] s1Cath[4];

    // Active-low cathode bytes {dp_n, ~gfedcba}: 0=C0 1=F9 2=A4 3=B0 4=99
    // 5=92 6=82 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E; 40 is 0 with dp lit.
    vecs[0]  = '{4'hE, 8'h99,   8, 1, 0, 0, 16'h0000, 4'h0};
    vecs[1]  = '{4'hD, 8'hB0,   8, 1, 0, 0, 16'h0000, 4'h0};
    vecs[2]  = '{4'hB, 8'hA4,   8, 1, 0, 0, 16'h0000, 4'h0};
    vecs[3]  = '{4'h7, 8'hF9,   8, 1, 0, 1, 16'h1234, 4'h0};
    vecs[4]  = '{4'hE, 8'hC0,   3, 0, 0, 0, 16'h1234, 4'h0};
    vecs[5]  = '{4'hE, 8'h86,   8, 1, 0, 0, 16'h1234, 4'h0};
    vecs[6]  = '{4'hD, 8'h92,   8, 1, 0, 0, 16'h1234, 4'h0};
    vecs[7]  = '{4'hD, 8'hFF,   8, 0, 1, 0, 16'h1234, 4'h0};
    vecs[8]  = '{4'hB, 8'h82,   8, 1, 0, 0, 16'h1234, 4'h0};
    vecs[9]  = '{4'h7, 8'h80,   8, 1, 0, 0, 16'h1234, 4'h0};
    vecs[10] = '{4'hD, 8'h90,   8, 1, 0, 1, 16'h869E, 4'h0};
    vecs[11] = '{4'hC, 8'h80,  20, 0, 0, 0, 16'h869E, 4'h0};
    vecs[12] = '{4'hF, 8'h80,  20, 0, 0, 0, 16'h869E, 4'h0};
    vecs[13] = '{4'hE, 8'h40, 100, 1, 0, 0, 16'h869E, 4'h0};
    vecs[14] = '{4'hD, 8'h88,   8, 1, 0, 0, 16'h869E, 4'h0};
    vecs[15] = '{4'hB, 8'h03,   8, 1, 0, 0, 16'h869E, 4'h0};
    vecs[16] = '{4'h7, 8'hC6,   8, 1, 0, 1, 16'hCBA0, 4'h5};
    vecs[17] = '{4'hE, 8'hA1,   8, 1, 0, 0, 16'hCBA0, 4'h5};
    vecs[18] = '{4'hE, 8'h8E,   8, 1, 0, 0, 16'hCBA0, 4'h5};
    vecs[19] = '{4'hD, 8'h80,   8, 1, 0, 0, 16'hCBA0, 4'h5};
    vecs[20] = '{4'hB, 8'h80,   8, 1, 0, 0, 16'hCBA0, 4'h5};
    vecs[21] = '{4'h7, 8'h80,   8, 1, 0, 1, 16'h888F, 4'h0};

    // Reset with an idle bus and confirm every output is cleared.
    BTNU     = 1'b1;
    AN       = 4'hF;
    Cathodes = 8'hFF;
    repeat (2) @(posedge sysclk);
    #1;
    checkOutput("reset value", 32'(value), 32'h0);
    checkOutput("reset dp", 32'(dp), 32'h0);
    checkOutput("reset valid", 32'(valid), 32'h0);
    checkOutput("reset digit_stb", 32'(digit_stb), 32'h0);
    checkOutput("reset seg_err", 32'(seg_err), 32'h0);
    BTNU = 1'b0;

    // Table-driven dwells.
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].an, vecs[i].cath, vecs[i].cycles, nStb, nErr, nValid);
      checkOutput($sformatf("row%0d digit_stb", i), 32'(nStb), 32'(vecs[i].expStb));
      checkOutput($sformatf("row%0d seg_err", i), 32'(nErr), 32'(vecs[i].expErr));
      checkOutput($sformatf("row%0d valid", i), 32'(nValid), 32'(vecs[i].expValid));
      checkOutput($sformatf("row%0d value", i), 32'(value), 32'(vecs[i].expValue));
      checkOutput($sformatf("row%0d dp", i), 32'(dp), 32'(vecs[i].expDp));
    end

    // Capture two digits, then reset while the second digit stays on the bus.
    applyStimulus(4'hE, 8'hC0, 8, nStb, nErr, nValid);
    checkOutput("pre-reset d0 stb", 32'(nStb), 32'd1);
    applyStimulus(4'hD, 8'hF9, 8, nStb, nErr, nValid);
    checkOutput("pre-reset d1 stb", 32'(nStb), 32'd1);
    BTNU = 1'b1;
    @(posedge sysclk);
    #1;
    checkOutput("midreset value", 32'(value), 32'h0);
    checkOutput("midreset dp", 32'(dp), 32'h0);
    checkOutput("midreset valid", 32'(valid), 32'h0);
    checkOutput("midreset digit_stb", 32'(digit_stb), 32'h0);
    checkOutput("midreset seg_err", 32'(seg_err), 32'h0);
    BTNU = 1'b0;

    // The sample still on the bus counts as new after reset. The strobe
    // should therefore appear right after the fourth edge.
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge sysclk);
      #1;
      if (digit_stb) begin
        lat = k;
        break;
      end
    end
    checkOutput("post-reset latency", 32'(lat), 32'd4);

    // Digits 2 and 3 alone must not complete a frame. Digit 0 must also
    // be captured again after the reset.
    applyStimulus(4'hB, 8'hA4, 8, nStb, nErr, nValid);
    checkOutput("post-reset d2 valid", 32'(nValid), 32'd0);
    applyStimulus(4'h7, 8'hB0, 8, nStb, nErr, nValid);
    checkOutput("post-reset d3 valid", 32'(nValid), 32'd0);
    checkOutput("post-reset value held", 32'(value), 32'h0);
    applyStimulus(4'hE, 8'hC0, 8, nStb, nErr, nValid);
    checkOutput("post-reset frame valid", 32'(nValid), 32'd1);
    checkOutput("post-reset frame value", 32'(value), 32'h3210);

    // STABLE_CYCLES=1 instance: every new digit is taken on its first edge.
    s1An[0] = 4'hE; s1Cath[0] = 8'hC0;
    s1An[1] = 4'hD; s1Cath[1] = 8'hF9;
    s1An[2] = 4'hB; s1Cath[2] = 8'hA4;
    s1An[3] = 4'h7; s1Cath[3] = 8'hB0;
    BTNU     = 1'b1;
    AN       = 4'hF;
    Cathodes = 8'hFF;
    @(posedge sysclk);
    #1;
    BTNU = 1'b0;
    for (int i = 0; i < 4; i++) begin
      AN       = s1An[i];
      Cathodes = s1Cath[i];
      @(posedge sysclk);
      #1;
      checkOutput($sformatf("s1 digit%0d stb", i), 32'(digitStb1), 32'd1);
    end
    checkOutput("s1 valid", 32'(valid1), 32'd1);
    checkOutput("s1 value", 32'(value1), 32'h3210);
    @(posedge sysclk);
    #1;
    checkOutput("s1 held no stb", 32'(digitStb1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checkCount, failCount);
    $finish;
  end

endmodule
